// File: rtl/wb_stream_reader_ctrl.sv
// Wishbone burst writer that drains a first-word-fall-through FIFO into a circular buffer.
// Optional feature macro: WB_STREAM_READER_ERR_ABORT_EN (abort on wbm_err_i, sticky err output).

module wb_stream_reader_ctrl #(
  parameter int unsigned WB_AW   = 32,
  parameter int unsigned WB_DW   = 32,
  parameter int unsigned FIFO_AW = 6
) (
  input  logic               clk,
  input  logic               rst,
  // FIFO side
  input  logic [WB_DW-1:0]   fifo_d,
  output logic               fifo_rd,
  input  logic [FIFO_AW:0]   fifo_cnt,
  // configuration
  input  logic               enable,
  input  logic [WB_AW-1:0]   start_adr,
  input  logic [31:0]        buf_size,
  input  logic [31:0]        burst_size,
  // Wishbone master
  output logic [WB_AW-1:0]   wbm_adr_o,
  output logic [WB_DW-1:0]   wbm_dat_o,
  output logic [WB_DW/8-1:0] wbm_sel_o,
  output logic               wbm_we_o,
  output logic               wbm_cyc_o,
  output logic               wbm_stb_o,
  output logic [2:0]         wbm_cti_o,
  output logic [1:0]         wbm_bte_o,
  input  logic               wbm_ack_i,
  input  logic               wbm_err_i,
  // status
  output logic               busy,
  output logic               irq
`ifdef WB_STREAM_READER_ERR_ABORT_EN
  ,
  output logic               err
`endif
);

  localparam logic [WB_AW-1:0] AdrStep = WB_AW'(WB_DW / 8);

  typedef enum logic [0:0] {StIdle, StBurst} state_e;

  state_e            state_q, state_d;
  logic [WB_AW-1:0]  adr_q, adr_d;
  logic [31:0]       words_done_q, words_done_d;
  logic [31:0]       beat_cnt_q, beat_cnt_d;
  logic [31:0]       buf_size_q, buf_size_d;
  logic [WB_AW-1:0]  start_adr_q, start_adr_d;
  logic              irq_q, irq_d;

  logic              in_burst;
  logic              last_beat;
  logic              beat_ack;
  logic              bus_err;
  logic              err_block;
  logic              restart;
  logic [31:0]       remaining;
  logic [31:0]       blen;
  logic              start_ok;

  assign in_burst  = (state_q == StBurst);
  assign last_beat = (beat_cnt_q == 32'd1);

`ifdef WB_STREAM_READER_ERR_ABORT_EN
  logic err_q;

  assign bus_err   = in_burst & wbm_err_i;
  assign err_block = err_q;
  assign err       = err_q;

  // Sticky until software drops enable; an abort in the same cycle wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (bus_err) begin
      err_q <= 1'b1;
    end else if (!enable) begin
      err_q <= 1'b0;
    end
  end
`else
  logic unused_err;

  assign unused_err = wbm_err_i;
  assign bus_err    = 1'b0;
  assign err_block  = 1'b0;
`endif

  assign beat_ack = in_burst & wbm_ack_i & ~bus_err;

  // A stale words_done (buf_size shrunk below it while idle) is treated as a fresh pass.
  assign restart   = (words_done_q == 32'd0) || (words_done_q >= buf_size);
  assign remaining = restart ? buf_size : (buf_size - words_done_q);
  assign blen      = (burst_size < remaining) ? burst_size : remaining;

  assign start_ok = enable && (buf_size != 32'd0) && (burst_size != 32'd0) &&
                    (32'(fifo_cnt) >= blen) && !err_block;

  always_comb begin
    state_d      = state_q;
    adr_d        = adr_q;
    words_done_d = words_done_q;
    beat_cnt_d   = beat_cnt_q;
    buf_size_d   = buf_size_q;
    start_adr_d  = start_adr_q;
    irq_d        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_ok) begin
          state_d     = StBurst;
          beat_cnt_d  = blen;
          buf_size_d  = buf_size;
          start_adr_d = start_adr;
          if (restart) begin
            adr_d        = start_adr;
            words_done_d = 32'd0;
          end
        end
      end

      StBurst: begin
        if (bus_err) begin
          state_d    = StIdle;
          beat_cnt_d = 32'd0;
        end else if (beat_ack) begin
          beat_cnt_d = beat_cnt_q - 32'd1;
          if (words_done_q + 32'd1 == buf_size_q) begin
            adr_d        = start_adr_q;
            words_done_d = 32'd0;
            irq_d        = 1'b1;
          end else begin
            adr_d        = adr_q + AdrStep;
            words_done_d = words_done_q + 32'd1;
          end
          if (last_beat) begin
            state_d = StIdle;
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      adr_q        <= '0;
      words_done_q <= 32'd0;
      beat_cnt_q   <= 32'd0;
      buf_size_q   <= 32'd0;
      start_adr_q  <= '0;
      irq_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      adr_q        <= adr_d;
      words_done_q <= words_done_d;
      beat_cnt_q   <= beat_cnt_d;
      buf_size_q   <= buf_size_d;
      start_adr_q  <= start_adr_d;
      irq_q        <= irq_d;
    end
  end

  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = fifo_d;
  assign wbm_sel_o = {(WB_DW / 8){in_burst}};
  assign wbm_we_o  = in_burst;
  assign wbm_cyc_o = in_burst;
  assign wbm_stb_o = in_burst;
  assign wbm_cti_o = in_burst ? (last_beat ? 3'b111 : 3'b010) : 3'b000;
  assign wbm_bte_o = 2'b00;

  // Reset gates the pop so a stray ack during reset cannot drain the FIFO.
  assign fifo_rd = wbm_ack_i & wbm_cyc_o & ~rst & ~bus_err;

  assign busy = in_burst;
  assign irq  = irq_q;

endmodule

// File: tb/tb_wb_stream_reader_ctrl.sv
// Self-checking bench for wb_stream_reader_ctrl: vector table plus corner-case sequences,
// with a beat scoreboard fed by a reference model of the address/length/wrap behaviour.

module tb_wb_stream_reader_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] fifo_d;
  logic        fifo_rd;
  logic [6:0]  fifo_cnt;
  logic        enable;
  logic [31:0] start_adr;
  logic [31:0] buf_size;
  logic [31:0] burst_size;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [3:0]  wbm_sel_o;
  logic        wbm_we_o;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic [2:0]  wbm_cti_o;
  logic [1:0]  wbm_bte_o;
  logic        ack;
  logic        err_in;
  logic        busy;
  logic        irq;
`ifdef WB_STREAM_READER_ERR_ABORT_EN
  logic        err;
`endif

  always #5 clk = ~clk;

  wb_stream_reader_ctrl #(
    .WB_AW  (32),
    .WB_DW  (32),
    .FIFO_AW(6)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .fifo_d    (fifo_d),
    .fifo_rd   (fifo_rd),
    .fifo_cnt  (fifo_cnt),
    .enable    (enable),
    .start_adr (start_adr),
    .buf_size  (buf_size),
    .burst_size(burst_size),
    .wbm_adr_o (wbm_adr_o),
    .wbm_dat_o (wbm_dat_o),
    .wbm_sel_o (wbm_sel_o),
    .wbm_we_o  (wbm_we_o),
    .wbm_cyc_o (wbm_cyc_o),
    .wbm_stb_o (wbm_stb_o),
    .wbm_cti_o (wbm_cti_o),
    .wbm_bte_o (wbm_bte_o),
    .wbm_ack_i (ack),
    .wbm_err_i (err_in),
    .busy      (busy),
    .irq       (irq)
`ifdef WB_STREAM_READER_ERR_ABORT_EN
    ,
    .err       (err)
`endif
  );

  typedef struct packed {
    logic [31:0] adr;
    logic [2:0]  cti;
    logic [31:0] dat;
    logic        wrap;
  } beat_t;

  typedef struct {
    int buf_sz;
    int burst_sz;
    int words;
    int stall_beat;
    int stall_len;
    int exp_beats;
    int exp_irqs;
  } vec_t;

  beat_t       sb[$];
  logic [31:0] fq[$];
  logic [31:0] pushed[$];

  int checks = 0;
  int errors = 0;
  int beats_seen, pops_seen, irqs_seen, cyc_cycles;
  int beat_idx, stall_beat, stall_len, stall_cnt, err_beat, err_len, err_cnt;
  int m_next, m_done;
  logic [31:0] m_adr;
  bit irq_exp, gap_exp, stalled;
  logic [31:0] snap_adr, snap_dat;
  logic [2:0]  snap_cti;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic sync_fifo();
    fifo_d   = (fq.size() != 0) ? fq[0] : 32'd0;
    fifo_cnt = 7'(fq.size());
  endtask

  task automatic push_words(input int n);
    logic [31:0] w;
    for (int i = 0; i < n; i++) begin
      w = 32'hA500_0000 + 32'(pushed.size());
      fq.push_back(w);
      pushed.push_back(w);
    end
    sync_fifo();
  endtask

  // Reference model: predicts the beats of up to max_bursts bursts from config and FIFO data.
  task automatic expect_bursts(input int max_bursts);
    int    blen, rem, nb;
    beat_t e;
    nb = 0;
    while (nb < max_bursts && buf_size != 0 && burst_size != 0) begin
      rem  = int'(buf_size) - m_done;
      blen = (int'(burst_size) < rem) ? int'(burst_size) : rem;
      if (pushed.size() - m_next < blen) break;
      if (m_done == 0) m_adr = start_adr;
      for (int i = 0; i < blen; i++) begin
        e.adr = m_adr;
        e.cti = (i == blen - 1) ? 3'b111 : 3'b010;
        e.dat = pushed[m_next];
        m_next++;
        m_done++;
        e.wrap = (m_done == int'(buf_size));
        if (e.wrap) begin
          m_done = 0;
          m_adr  = start_adr;
        end else begin
          m_adr = m_adr + 32'd4;
        end
        sb.push_back(e);
      end
      nb++;
    end
  endtask

  // One clock: slave drives ack/err at the falling edge, outputs are sampled 1ns later.
  task automatic step();
    beat_t e;
    @(negedge clk);
    ack    = 1'b0;
    err_in = 1'b0;
    if (wbm_cyc_o && wbm_stb_o) begin
      if (beat_idx == err_beat && err_cnt < err_len) begin
        err_in = 1'b1;
        err_cnt++;
      end else if (beat_idx == stall_beat && stall_cnt < stall_len) begin
        stall_cnt++;
      end else begin
        ack = 1'b1;
      end
    end
    #1;
    if (!rst) begin
      chk("irq", 64'(irq), 64'(irq_exp));
      if (gap_exp) chk("idle_gap", 64'(wbm_cyc_o), 64'd0);
    end
    irq_exp = 1'b0;
    gap_exp = 1'b0;
    if (irq) irqs_seen++;
    if (wbm_cyc_o) cyc_cycles++;
    if (rst) begin
      chk("rd_in_rst", 64'(fifo_rd), 64'd0);
    end else if (wbm_cyc_o && wbm_stb_o && ack) begin
      chk("rd_on_ack", 64'(fifo_rd), 64'd1);
      chk("beat_expected", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("adr", 64'(wbm_adr_o), 64'(e.adr));
        chk("cti", 64'(wbm_cti_o), 64'(e.cti));
        chk("dat", 64'(wbm_dat_o), 64'(e.dat));
        chk("ctl", 64'({wbm_we_o, wbm_sel_o, wbm_bte_o}), 64'({1'b1, 4'hF, 2'b00}));
        irq_exp = e.wrap;
        gap_exp = (e.cti == 3'b111);
      end
      beats_seen++;
      beat_idx++;
      stall_cnt = 0;
      err_cnt   = 0;
      stalled   = 1'b0;
    end else if (wbm_cyc_o) begin
      chk("rd_no_ack", 64'(fifo_rd), 64'd0);
      if (stalled) begin
        chk("stall_adr", 64'(wbm_adr_o), 64'(snap_adr));
        chk("stall_dat", 64'(wbm_dat_o), 64'(snap_dat));
        chk("stall_cti", 64'(wbm_cti_o), 64'(snap_cti));
      end
      snap_adr = wbm_adr_o;
      snap_dat = wbm_dat_o;
      snap_cti = wbm_cti_o;
      stalled  = 1'b1;
    end else begin
      stalled = 1'b0;
    end
    if (fifo_rd) begin
      pops_seen++;
      if (fq.size() != 0) fq.delete(0);
      sync_fifo();
    end
  endtask

  task automatic run_idle(input int budget);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while ((sb.size() != 0 || wbm_cyc_o) && n < budget);
    if (sb.size() != 0 || wbm_cyc_o) begin
      checks++;
      errors++;
      $display("FAIL timeout actual=%0d beats pending required=0", sb.size());
    end
    repeat (4) step();
    chk("sb_empty", 64'(sb.size()), 64'd0);
  endtask

  task automatic step_until_beat(input int target);
    int n;
    n = 0;
    while (beat_idx < target && n < 50) begin
      step();
      n++;
    end
    chk("reach_beat", 64'(beat_idx), 64'(target));
  endtask

  task automatic reset_all();
    rst        = 1'b1;
    enable     = 1'b0;
    ack        = 1'b0;
    err_in     = 1'b0;
    start_adr  = 32'h1000;
    buf_size   = 32'd0;
    burst_size = 32'd0;
    sb.delete();
    fq.delete();
    pushed.delete();
    m_next = 0;
    m_done = 0;
    m_adr  = 32'd0;
    beats_seen = 0;
    pops_seen  = 0;
    irqs_seen  = 0;
    cyc_cycles = 0;
    beat_idx   = 0;
    stall_beat = -1;
    stall_len  = 0;
    stall_cnt  = 0;
    err_beat   = -1;
    err_len    = 0;
    err_cnt    = 0;
    irq_exp    = 1'b0;
    gap_exp    = 1'b0;
    stalled    = 1'b0;
    sync_fifo();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    //          buf burst words stall_b stall_l beats irqs
    vecs[0] = '{4,  1,    1,    -1,     0,      1,    0};
    vecs[1] = '{16, 4,    4,    1,      2,      4,    0};
    vecs[2] = '{6,  4,    6,    -1,     0,      6,    1};
    vecs[3] = '{3,  8,    7,    -1,     0,      6,    2};
    vecs[4] = '{5,  2,    5,    0,      1,      5,    1};
    vecs[5] = '{0,  4,    4,    -1,     0,      0,    0};
    vecs[6] = '{4,  0,    4,    -1,     0,      0,    0};
    vecs[7] = '{4,  4,    3,    -1,     0,      0,    0};

    // Reset state
    reset_all();
    #1;
    chk("rst_ctl", 64'({wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_cti_o}), 64'd0);
    chk("rst_adr", 64'(wbm_adr_o), 64'd0);
    chk("rst_status", 64'({busy, irq, fifo_rd}), 64'd0);
`ifdef WB_STREAM_READER_ERR_ABORT_EN
    chk("rst_err", 64'(err), 64'd0);
`endif

    for (int v = 0; v < 8; v++) begin
      reset_all();
      buf_size   = 32'(vecs[v].buf_sz);
      burst_size = 32'(vecs[v].burst_sz);
      stall_beat = vecs[v].stall_beat;
      stall_len  = vecs[v].stall_len;
      push_words(vecs[v].words);
      enable = 1'b1;
      expect_bursts(100);
      run_idle(200);
      chk($sformatf("v%0d_beats", v), 64'(beats_seen), 64'(vecs[v].exp_beats));
      chk($sformatf("v%0d_pops", v), 64'(pops_seen), 64'(vecs[v].exp_beats));
      chk($sformatf("v%0d_irqs", v), 64'(irqs_seen), 64'(vecs[v].exp_irqs));
    end

    // FIFO threshold, short second burst and wrap
    reset_all();
    buf_size   = 32'd6;
    burst_size = 32'd4;
    push_words(3);
    enable = 1'b1;
    repeat (10) step();
    chk("thresh_no_cyc", 64'(cyc_cycles), 64'd0);
    push_words(1);
    expect_bursts(100);
    run_idle(100);
    push_words(2);
    expect_bursts(100);
    run_idle(100);
    chk("thresh_beats", 64'(beats_seen), 64'd6);
    chk("thresh_irqs", 64'(irqs_seen), 64'd1);
    chk("wrap_adr", 64'(wbm_adr_o), 64'h1000);

    // Enable dropped mid-burst
    reset_all();
    buf_size   = 32'd16;
    burst_size = 32'd4;
    push_words(8);
    enable = 1'b1;
    expect_bursts(1);
    step_until_beat(1);
    chk("busy_mid", 64'(busy), 64'd1);
    enable = 1'b0;
    push_words(1);
    run_idle(100);
    repeat (10) step();
    chk("dis_beats", 64'(beats_seen), 64'd4);
    chk("dis_pops", 64'(pops_seen), 64'd4);
    chk("dis_idle", 64'(wbm_cyc_o), 64'd0);

    // Reset mid-burst
    reset_all();
    buf_size   = 32'd16;
    burst_size = 32'd4;
    push_words(4);
    enable = 1'b1;
    expect_bursts(1);
    step_until_beat(1);
    rst = 1'b1;
    step();
    step();
    chk("rst_mid_cyc", 64'(wbm_cyc_o), 64'd0);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_adr", 64'(wbm_adr_o), 64'd0);
    chk("rst_mid_pops", 64'(pops_seen), 64'd1);

    // Bus error on beat 2
    reset_all();
    buf_size   = 32'd16;
    burst_size = 32'd4;
    push_words(4);
    enable   = 1'b1;
    err_beat = 1;
    err_len  = 2;
    expect_bursts(1);
`ifdef WB_STREAM_READER_ERR_ABORT_EN
    repeat (12) step();
    chk("err_beats", 64'(beats_seen), 64'd1);
    chk("err_pops", 64'(pops_seen), 64'd1);
    chk("err_flag", 64'(err), 64'd1);
    sb.delete();
    push_words(1);
    repeat (8) step();
    chk("err_blocks", 64'(beats_seen), 64'd1);
    enable = 1'b0;
    step();
    chk("err_clear", 64'(err), 64'd0);
`else
    run_idle(100);
    chk("err_beats", 64'(beats_seen), 64'd4);
    chk("err_pops", 64'(pops_seen), 64'd4);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
